// File: rtl/cache_pkg.sv
// Shared types for the line age tracker: age type, saturation limit, flush FSM.
// Optional perf counters in the top are enabled by LINE_AGE_PERF_EN.
package cache_pkg;

    typedef logic [31:0] age_t;

    localparam age_t AGE_MAX = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_st_e;

    function automatic age_t age_inc(input age_t a);
        return (a == AGE_MAX) ? a : a + 32'd1;
    endfunction

endpackage

// File: rtl/age_set_update.sv
// One set of valid/age state with access, invalidate and flush-clear update.
// Exposes next-state so the top can forward same-cycle updates to lookups.
module age_set_update
    import cache_pkg::*;
#(
    parameter int N_WAYS = 2,
    parameter int N_POW  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    acc_en_i,
    input  logic                    acc_fill_i,
    input  logic [N_POW-1:0]        acc_way_i,
    input  logic                    inv_en_i,
    input  logic [N_POW-1:0]        inv_way_i,
    output logic [N_WAYS-1:0]       valid_d_o,
    output age_t [N_WAYS-1:0]       age_d_o
);

    logic [N_WAYS-1:0] valid_q, valid_d;
    age_t [N_WAYS-1:0] age_q, age_d;

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        for (int w = 0; w < N_WAYS; w++) begin
            if (clr_i) begin
                valid_d[w] = 1'b0;
                age_d[w]   = '0;
            end else begin
                if (acc_en_i) begin
                    if (acc_way_i == N_POW'(w)) begin
                        age_d[w] = '0;
                        if (acc_fill_i) valid_d[w] = 1'b1;
                    end else if (valid_q[w]) begin
                        age_d[w] = age_inc(age_q[w]);
                    end
                end
                // Invalidate is applied last so it wins over a same-way access.
                if (inv_en_i && (inv_way_i == N_POW'(w))) begin
                    valid_d[w] = 1'b0;
                    age_d[w]   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    assign valid_d_o = valid_d;
    assign age_d_o   = age_d;

endmodule

// File: rtl/line_age_tracker.sv
// Per-set, per-way valid and age tracking with sequential flush and lookup port.
// Define LINE_AGE_PERF_EN to add hit_cnt/fill_cnt performance counters.
module line_age_tracker
    import cache_pkg::*;
#(
    parameter int N_WAYS   = 2,
    parameter int N_POW    = 4,
    parameter int N_SETS   = 16,
    parameter int SET_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                acc_valid,
    input  logic                acc_fill,
    input  logic [SET_BITS-1:0] acc_set,
    input  logic [N_POW-1:0]    acc_way,
    input  logic                inv_valid,
    input  logic [SET_BITS-1:0] inv_set,
    input  logic [N_POW-1:0]    inv_way,
    input  logic                flush_req,
    output logic                busy,
    input  logic [SET_BITS-1:0] lookup_set,
    output logic                line_empty [N_WAYS],
    output age_t                line_age   [N_WAYS]
`ifdef LINE_AGE_PERF_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         fill_cnt
`endif
);

    flush_st_e           st_q, st_d;
    logic [SET_BITS-1:0] fset_q, fset_d;
    logic                acc_ok, inv_ok;

    logic [N_WAYS-1:0]   set_valid_d [N_SETS];
    age_t [N_WAYS-1:0]   set_age_d   [N_SETS];

    logic                line_empty_q [N_WAYS];
    age_t                line_age_q   [N_WAYS];

    assign busy   = (st_q == ST_FLUSH);
    assign acc_ok = acc_valid && !busy && (int'(acc_way) < N_WAYS);
    assign inv_ok = inv_valid && !busy && (int'(inv_way) < N_WAYS);

    for (genvar s = 0; s < N_SETS; s++) begin : g_set
        age_set_update #(
            .N_WAYS (N_WAYS),
            .N_POW  (N_POW)
        ) u_set (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr_i      (busy && (fset_q == SET_BITS'(s))),
            .acc_en_i   (acc_ok && (acc_set == SET_BITS'(s))),
            .acc_fill_i (acc_fill),
            .acc_way_i  (acc_way),
            .inv_en_i   (inv_ok && (inv_set == SET_BITS'(s))),
            .inv_way_i  (inv_way),
            .valid_d_o  (set_valid_d[s]),
            .age_d_o    (set_age_d[s])
        );
    end

    always_comb begin
        st_d   = st_q;
        fset_d = fset_q;
        unique case (st_q)
            ST_IDLE: begin
                if (flush_req) begin
                    st_d   = ST_FLUSH;
                    fset_d = '0;
                end
            end
            ST_FLUSH: begin
                if (fset_q == SET_BITS'(N_SETS - 1)) st_d = ST_IDLE;
                else fset_d = fset_q + SET_BITS'(1);
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            fset_q <= '0;
        end else begin
            st_q   <= st_d;
            fset_q <= fset_d;
        end
    end

    // Lookup registers sample next-state so same-edge updates are visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WAYS; i++) begin
                line_empty_q[i] <= 1'b1;
                line_age_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_WAYS; i++) begin
                line_empty_q[i] <= !set_valid_d[lookup_set][i];
                line_age_q[i]   <= set_age_d[lookup_set][i];
            end
        end
    end

    assign line_empty = line_empty_q;
    assign line_age   = line_age_q;

`ifdef LINE_AGE_PERF_EN
    logic [31:0] hit_cnt_q, fill_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            fill_cnt_q <= '0;
        end else if (acc_ok) begin
            if (acc_fill) fill_cnt_q <= fill_cnt_q + 32'd1;
            else          hit_cnt_q  <= hit_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign fill_cnt = fill_cnt_q;
`endif

endmodule

// File: doc/line_age_tracker.md
LINE_AGE_TRACKER -- requirements
Module: line_age_tracker

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_WAYS, 2, ways per set.
- N_POW, 4, way-index width.
- N_SETS, 16, number of sets.
- SET_BITS, 4, set-index width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- acc_valid, in, 1, access (hit or fill) this cycle.
- acc_fill, in, 1, 1 = fill (line becomes valid), 0 = hit.
- acc_set, in, SET_BITS, set of the access.
- acc_way, in, N_POW, way of the access.
- inv_valid, in, 1, invalidate request.
- inv_set, in, SET_BITS, set to invalidate.
- inv_way, in, N_POW, way to invalidate.
- flush_req, in, 1, pulse; invalidate all lines.
- busy, out, 1, flush in progress.
- lookup_set, in, SET_BITS, set whose status is reported.
- line_empty, out, 1 x N_WAYS unpacked, per-way empty flag; feeds the victim selector.
- line_age, out, 32 x N_WAYS unpacked, per-way age; feeds the victim selector.

Function
REQ-003 Storage SHALL be valid[N_SETS][N_WAYS] plus a 32-bit age[N_SETS][N_WAYS]; larger age means older (preferred victim).
REQ-004 An accepted access SHALL set age[acc_set][acc_way] to 0 and add 1 to every other valid way in that set, saturating at 32'hFFFF_FFFF.
- Ages of invalid ways SHALL NOT change.
REQ-005 A fill SHALL also set valid[acc_set][acc_way] to 1.
- A hit to an invalid way SHALL still update ages but leave valid at 0.
REQ-006 An invalidate SHALL clear valid and age of inv_way in inv_set; other ways SHALL be unaffected.
REQ-007 Simultaneous access and invalidate:
- Same set and same way: invalidate SHALL win (valid=0, age=0); the other ways still age per REQ-004.
- Different set or way: both SHALL take effect in the same cycle.
REQ-008 An acc_way or inv_way value of N_WAYS or more SHALL be ignored with no state change.
REQ-009 line_empty and line_age SHALL be registered with 1-cycle latency: the value at edge t+1 reflects lookup_set sampled at edge t, after that edge's updates (same-set updates forwarded).
REQ-010 line_empty[i] SHALL equal !valid[lookup_set][i].
REQ-011 The state machine SHALL have two states, IDLE and FLUSH.
- IDLE to FLUSH on flush_req=1.
- FLUSH clears valid and age of one set per cycle, set 0 first, ascending.
- FLUSH returns to IDLE after set N_SETS-1 is cleared, so the flush takes exactly N_SETS cycles.
REQ-012 busy SHALL be 1 exactly while in FLUSH.
- acc_valid, inv_valid and flush_req SHALL be ignored while busy=1.
- Lookups SHALL continue during FLUSH, and already-cleared sets SHALL read as empty.
REQ-013 If flush_req and acc_valid are both 1 in IDLE, the access SHALL apply and then the flush SHALL start on the next cycle.

Reset
REQ-014 On rst_n=0 the block SHALL, asynchronously:
- clear all valid and age entries;
- enter IDLE with busy=0;
- drive line_empty all 1 and line_age all 0.
REQ-015 Reset asserted during FLUSH SHALL abort the flush; the block SHALL resume in IDLE after release.

Configuration
REQ-016 With macro LINE_AGE_PERF_EN defined, the block SHALL add two outputs, hit_cnt and fill_cnt (32 bits each).
- Each counts accepted hits or fills respectively.
- Both wrap at 2^32, reset to 0, and are not cleared by flush.
REQ-017 Without LINE_AGE_PERF_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-018 Shared package cache_pkg SHALL hold the age_t typedef (32-bit), the age saturation constant AGE_MAX, and the flush-state enum.
REQ-019 Per-set update logic (REQ-004 to REQ-007) SHALL be a sub-module age_set_update, instantiated once per set.

Verification
REQ-020 The bench SHALL cover these directed scenarios (N_WAYS=2):
- Reset then lookup_set=3: next cycle line_empty={1,1}, line_age={0,0}.
- Fill set 3 way 0, then fill set 3 way 1: lookup shows empty={0,0}, age={1,0}.
- Preload set 5 way 1 age to 32'hFFFF_FFFF (via forced state), then hit way 0: age[1] stays 32'hFFFF_FFFF.
- Fill and invalidate set 2 way 1 in the same cycle: empty[1]=1, age[1]=0.
- Fill sets 0 and 15, then flush_req: busy=1 for 16 cycles; a write during busy is ignored; afterwards both sets read empty.
- Assert rst_n=0 at flush cycle 5: busy=0 immediately; after release, all sets read empty.
